// File: rtl/seven_seg_message_scroller.sv
// ---------------------------------------------------------------------------
// seven_seg_message_scroller
//
// Purpose:
//    Multiplexed N-digit 7-segment driver with a loadable message buffer.
//    Up to MSG_DEPTH segment patterns are loaded one character per transfer
//    and shown right-to-left across N_DIGITS digits. Messages longer than the
//    display scroll by one character per scroll tick. Segment and digit
//    outputs are active low (0 = lit / 0 = selected).
//
// Ports:
//    clk        in   1         clock
//    reset      in   1         asynchronous, active-high reset
//    wr_valid   in   1         message character valid
//    wr_ready   out  1         buffer accepts a character (1 from the first
//                              clock after reset onward)
//    wr_char    in   8         character as an abcdefgh pattern (0 = lit)
//    wr_last    in   1         marks the final character of the message
//    scroll_en  in   1         1 = scroll long messages, 0 = freeze offset
//    blink      in   1         (SEVEN_SEG_SCROLLER_BLINK_EN only) blank the
//                              segments on alternate scroll periods
//    abcdefgh   out  8         segment drive (0 = lit)
//    digit      out  N_DIGITS  digit select, one-hot-low, digit 0 rightmost
//
// Configuration:
//    Define SEVEN_SEG_SCROLLER_BLINK_EN to add the blink input and the
//    phase register that toggles on every scroll tick.
// ---------------------------------------------------------------------------
module seven_seg_message_scroller #(
   parameter int N_DIGITS     = 4,
   parameter int MSG_DEPTH    = 16,
   parameter int REFRESH_BITS = 16,
   parameter int SCROLL_BITS  = 23
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_valid,
   output logic                wr_ready,
   input  logic [7:0]          wr_char,
   input  logic                wr_last,
   input  logic                scroll_en,
`ifdef SEVEN_SEG_SCROLLER_BLINK_EN
   input  logic                blink,
`endif
   output logic [7:0]          abcdefgh,
   output logic [N_DIGITS-1:0] digit
);

   localparam int IW = $clog2(MSG_DEPTH);
   localparam int AW = IW + 1;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      LOADING = 2'd1,
      RUNNING = 2'd2
   } state_t;

   state_t                  state;
   logic [AW-1:0]           len;
   logic [AW-1:0]           ptr;
   logic [AW-1:0]           offset;
   logic [N_DIGITS-1:0]     sel;
   logic [REFRESH_BITS-1:0] refresh_cnt;
   logic [SCROLL_BITS-1:0]  scroll_cnt;
   logic [7:0]              msg_buf [MSG_DEPTH];

   logic                    transfer;
   logic                    scroll_tick;
   logic [IW-1:0]           wr_addr;
   logic [AW-1:0]           pos;
   logic [AW-1:0]           idx_sum;
   logic [IW-1:0]           rd_idx;

`ifdef SEVEN_SEG_SCROLLER_BLINK_EN
   logic                    phase;
`endif

   assign transfer    = wr_valid & wr_ready;
   assign scroll_tick = (scroll_cnt == '0);

   // A transfer outside LOADING always begins a fresh message at slot 0.
   assign wr_addr = (state == LOADING) ? ptr[IW-1:0] : '0;

   // Message storage is not reset; the state machine decides what is visible.
   always_ff @(posedge clk) begin
      if (transfer)
         msg_buf[wr_addr] <= wr_char;
   end

   // Load/run state machine. A transfer always wins over a scroll tick, so a
   // tick landing on the load-completing cycle leaves offset at 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= EMPTY;
         len      <= '0;
         ptr      <= '0;
         offset   <= '0;
         wr_ready <= 1'b0;
      end else begin
         wr_ready <= 1'b1;
         if (transfer) begin
            if (state == LOADING) begin
               ptr <= ptr + AW'(1);
               if (wr_last || ptr == AW'(MSG_DEPTH - 1)) begin
                  state  <= RUNNING;
                  len    <= ptr + AW'(1);
                  offset <= '0;
               end
            end else begin
               ptr    <= AW'(1);
               offset <= '0;
               if (wr_last || MSG_DEPTH == 1) begin
                  state <= RUNNING;
                  len   <= AW'(1);
               end else begin
                  state <= LOADING;
                  len   <= '0;
               end
            end
         end else if (scroll_tick && state == RUNNING && scroll_en &&
                      len > AW'(N_DIGITS)) begin
            offset <= (offset == len - AW'(1)) ? '0 : offset + AW'(1);
         end
      end
   end

   // Free-running refresh and scroll counters; the digit scan advances the
   // cycle the refresh counter reads zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         refresh_cnt <= '0;
         scroll_cnt  <= '0;
         sel         <= N_DIGITS'(1);
`ifdef SEVEN_SEG_SCROLLER_BLINK_EN
         phase       <= 1'b0;
`endif
      end else begin
         refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
         scroll_cnt  <= scroll_cnt + SCROLL_BITS'(1);
         if (refresh_cnt == '0)
            sel <= {sel[N_DIGITS-2:0], sel[N_DIGITS-1]};
`ifdef SEVEN_SEG_SCROLLER_BLINK_EN
         if (scroll_tick)
            phase <= ~phase;
`endif
      end
   end

   // Segment pattern for the selected digit. Since offset < len and
   // pos < len whenever the character is shown, offset+pos < 2*len and a
   // single compare-subtract gives the modulo.
   always_comb begin
      pos = '0;
      for (int i = 0; i < N_DIGITS; i++)
         if (sel[i])
            pos = AW'(N_DIGITS - 1 - i);
      idx_sum = offset + pos;
      rd_idx  = (idx_sum >= len) ? IW'(idx_sum - len) : IW'(idx_sum);
      if (state == RUNNING && pos < len)
         abcdefgh = msg_buf[rd_idx];
      else
         abcdefgh = 8'hFF;
`ifdef SEVEN_SEG_SCROLLER_BLINK_EN
      if (blink && phase)
         abcdefgh = 8'hFF;
`endif
   end

   assign digit = ~sel;

endmodule
